// File: rtl/proj_mem_unloader.sv
// Streams a window of the Q/K/V projection SRAM out over a valid/ready port.
// Reads are credit-limited so every word in flight always has a FIFO slot waiting for it.
module proj_mem_unloader #(
    parameter int unsigned READ_LAT   = 2,
    parameter int unsigned AW         = 7,
    parameter int unsigned DW         = 128,
    parameter int unsigned FIFO_DEPTH = READ_LAT + 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    sel,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   num_words,
    output logic [1:0]    mem_sel,
    output logic          mem_ceb,
    output logic          mem_web,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_last,
    output logic          busy,
    output logic          done
);
    localparam int unsigned NW = AW + 1;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned EW = DW + AW + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

    state_e              state_q, state_d;
    logic [1:0]          sel_q, sel_d;
    logic [AW-1:0]       base_q, base_d;
    logic [NW-1:0]       num_q, num_d;
    logic [NW-1:0]       issued_q, issued_d;
    logic [CW-1:0]       credit_q, credit_d;
    logic [CW-1:0]       occ_q, occ_d;
    logic                ceb_q, ceb_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [READ_LAT-1:0] pv_q, pv_d;
    logic [READ_LAT-1:0] pl_q, pl_d;
    logic [AW-1:0]       pa_q [READ_LAT];
    logic [AW-1:0]       pa_d [READ_LAT];
    logic [EW-1:0]       fifo_q [FIFO_DEPTH];
    logic [EW-1:0]       fifo_d [FIFO_DEPTH];
    logic [PW-1:0]       rd_q, rd_d, wr_q, wr_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                issue;
    logic                pop;
    logic                push;
    logic [EW-1:0]       head;

    assign issue = ~ceb_q;
    assign pop   = out_valid_q & out_ready;
    assign push  = pv_q[READ_LAT-1];
    assign head  = fifo_q[rd_q];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        base_d      = base_q;
        num_d       = num_q;
        issued_d    = issued_q + NW'(issue);
        credit_d    = credit_q + CW'(issue) - CW'(pop);
        occ_d       = occ_q + CW'(push) - CW'(pop);
        rd_d        = rd_q;
        wr_d        = wr_q;
        fifo_d      = fifo_q;
        addr_d      = addr_q;
        ceb_d       = 1'b1;
        pv_d        = '0;
        pl_d        = '0;
        pa_d        = pa_q;

        // Capture pipeline: stage k holds the read issued k+1 cycles ago.
        pv_d[0] = issue;
        pl_d[0] = issue && (issued_q == num_q - NW'(1));
        pa_d[0] = addr_q;
        for (int k = 1; k < int'(READ_LAT); k++) begin
            pv_d[k] = pv_q[k-1];
            pl_d[k] = pl_q[k-1];
            pa_d[k] = pa_q[k-1];
        end

        if (push) begin
            fifo_d[wr_q] = {mem_dout, pa_q[READ_LAT-1], pl_q[READ_LAT-1]};
            wr_d         = ptr_inc(wr_q);
        end
        if (pop) begin
            rd_d = ptr_inc(rd_q);
        end

        case (state_q)
            IDLE: begin
                if (start && (sel != 2'd3)) begin
                    sel_d    = sel;
                    base_d   = base_addr;
                    num_d    = num_words;
                    issued_d = '0;
                    state_d  = READ;
                end
            end
            READ: begin
                // An empty readout spends its single READ cycle and goes straight to DONE.
                if (issued_d == num_q) begin
                    state_d = (num_q == '0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head[0]) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Decide next cycle's issue now so the SRAM controls come straight from flops.
        if ((state_d == READ) && (issued_d < num_d) && (credit_d < CW'(FIFO_DEPTH))) begin
            ceb_d  = 1'b0;
            addr_d = base_d + issued_d[AW-1:0];
        end

        out_valid_d = (occ_d != '0);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            base_q      <= '0;
            num_q       <= '0;
            issued_q    <= '0;
            credit_q    <= '0;
            occ_q       <= '0;
            ceb_q       <= 1'b1;
            addr_q      <= '0;
            pv_q        <= '0;
            pl_q        <= '0;
            for (int k = 0; k < int'(READ_LAT); k++) begin
                pa_q[k] <= '0;
            end
            for (int k = 0; k < int'(FIFO_DEPTH); k++) begin
                fifo_q[k] <= '0;
            end
            rd_q        <= '0;
            wr_q        <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            base_q      <= base_d;
            num_q       <= num_d;
            issued_q    <= issued_d;
            credit_q    <= credit_d;
            occ_q       <= occ_d;
            ceb_q       <= ceb_d;
            addr_q      <= addr_d;
            pv_q        <= pv_d;
            pl_q        <= pl_d;
            pa_q        <= pa_d;
            fifo_q      <= fifo_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mem_sel   = sel_q;
    assign mem_ceb   = ceb_q;
    assign mem_web   = 1'b1;
    assign mem_addr  = addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = head[EW-1 -: DW];
    assign out_addr  = head[AW:1];
    assign out_last  = head[0] & out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_proj_mem_unloader.sv
// Randomized scoreboard bench for proj_mem_unloader against an SRAM model and
// an expected-word queue built directly from each readout's base/num.
module tb_proj_mem_unloader;
    localparam int L     = 2;
    localparam int AW    = 7;
    localparam int DW    = 128;
    localparam int DEPTH = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    sel = '0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_words = '0;
    logic [1:0]    mem_sel;
    logic          mem_ceb;
    logic          mem_web;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;
    logic          done;

    proj_mem_unloader #(.READ_LAT(L), .AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .sel(sel), .base_addr(base_addr),
        .num_words(num_words), .mem_sel(mem_sel), .mem_ceb(mem_ceb), .mem_web(mem_web),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // SRAM model: data appears READ_LAT cycles after the address cycle, junk otherwise.
    logic [DW-1:0] sram [128];
    logic [AW-1:0] sa [L];
    logic [L-1:0]  sv = '0;
    logic [DW-1:0] junk = '0;
    always @(posedge clk) begin
        sv[0] <= ~mem_ceb;
        sa[0] <= mem_addr;
        for (int k = 1; k < L; k++) begin
            sv[k] <= sv[k-1];
            sa[k] <= sa[k-1];
        end
        junk <= {$urandom, $urandom, $urandom, $urandom};
    end
    assign mem_dout = sv[L-1] ? sram[sa[L-1]] : junk;

    // Ready driver: held low until hold_until, otherwise high with ready_pct percent.
    int ready_pct  = 100;
    int hold_until = -1;
    always @(posedge clk) begin
        #1;
        if (cyc <= hold_until) out_ready = 1'b0;
        else out_ready = ($urandom_range(0, 99) < ready_pct);
    end

    // Scoreboard queues.
    logic [DW-1:0] exp_data  [$];
    logic [AW-1:0] exp_oaddr [$];
    logic          exp_last  [$];
    logic [AW-1:0] exp_iaddr [$];

    // Per-readout observations.
    int       t0;
    logic [1:0] cur_sel;
    int issue_cnt, first_issue, last_issue, first_valid, first_valid_addr;
    int last_cyc, last_addr, done_cyc, done_cnt, busy_cnt, busy_first, busy_last;
    int pop_cnt, issues_at_first_pop;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addr;
    logic          prev_last;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            check("mem_web", DW'(mem_web), DW'(1));
            if (prev_stall) begin
                check("stall_valid", DW'(out_valid), DW'(1));
                check("stall_data", out_data, prev_data);
                check("stall_addr", DW'(out_addr), DW'(prev_addr));
                check("stall_last", DW'(out_last), DW'(prev_last));
            end
            if (out_valid && first_valid < 0) begin
                first_valid      = cyc;
                first_valid_addr = int'(out_addr);
            end
            if (out_valid && out_ready) begin
                if (pop_cnt == 0) issues_at_first_pop = issue_cnt;
                pop_cnt++;
                if (exp_data.size() == 0) begin
                    check_int("unexpected_word", 1, 0);
                end else begin
                    check("out_data", out_data, exp_data.pop_front());
                    check("out_addr", DW'(out_addr), DW'(exp_oaddr.pop_front()));
                    check("out_last", DW'(out_last), DW'(exp_last.pop_front()));
                end
                if (out_last) begin
                    last_cyc  = cyc;
                    last_addr = int'(out_addr);
                end
            end
            if (!mem_ceb) begin
                if (issue_cnt == 0) first_issue = cyc;
                last_issue = cyc;
                issue_cnt++;
                if (exp_iaddr.size() == 0) check_int("unexpected_issue", 1, 0);
                else check("mem_addr", DW'(mem_addr), DW'(exp_iaddr.pop_front()));
            end
            if (busy) begin
                if (busy_cnt == 0) busy_first = cyc;
                busy_last = cyc;
                busy_cnt++;
                check("mem_sel", DW'(mem_sel), DW'(cur_sel));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = out_valid & ~out_ready;
            prev_data  = out_data;
            prev_addr  = out_addr;
            prev_last  = out_last;
        end
    end

    task automatic clear_queues();
        exp_data.delete();
        exp_oaddr.delete();
        exp_last.delete();
        exp_iaddr.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ceb"}, DW'(mem_ceb), DW'(1));
        check({tag, "_web"}, DW'(mem_web), DW'(1));
        check({tag, "_maddr"}, DW'(mem_addr), '0);
        check({tag, "_msel"}, DW'(mem_sel), '0);
        check({tag, "_valid"}, DW'(out_valid), '0);
        check({tag, "_last"}, DW'(out_last), '0);
        check({tag, "_busy"}, DW'(busy), '0);
        check({tag, "_done"}, DW'(done), '0);
        check({tag, "_data"}, out_data, '0);
        check({tag, "_oaddr"}, DW'(out_addr), '0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (busy) check_int("idle_timeout", 1, 0);
    endtask

    task automatic run(input logic [1:0] s, input int base, input int num, input bit poke);
        wait_idle();
        if (s != 2'd3) begin
            for (int i = 0; i < num; i++) begin
                logic [AW-1:0] a;
                a = AW'((base + i) % 128);
                exp_data.push_back(sram[a]);
                exp_oaddr.push_back(a);
                exp_last.push_back(i == num - 1);
                exp_iaddr.push_back(a);
            end
            cur_sel = s;
        end
        issue_cnt = 0; first_issue = -1; last_issue = -1; first_valid = -1;
        first_valid_addr = -1; last_cyc = -1; last_addr = -1; done_cyc = -1;
        done_cnt = 0; busy_cnt = 0; busy_first = -1; busy_last = -1;
        pop_cnt = 0; issues_at_first_pop = -1;
        @(posedge clk); #1;
        start = 1'b1; sel = s; base_addr = AW'(base); num_words = (AW+1)'(num);
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        if (poke) begin
            @(posedge clk); #1;
            start = 1'b1;
            sel = 2'($urandom_range(0, 2));
            base_addr = AW'($urandom_range(0, 127));
            num_words = (AW+1)'($urandom_range(1, 128));
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        check_int({tag, "_done_once"}, done_cnt, 1);
        check_int({tag, "_leftover"}, exp_data.size() + exp_iaddr.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) sram[i] = {$urandom, $urandom, $urandom, $urandom};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Full readout, ready always high.
        ready_pct = 100;
        run(2'd0, 0, 128, 1'b0);
        wait_done("full");
        check_int("full_first_issue", first_issue, t0 + 1);
        check_int("full_last_issue", last_issue, t0 + 128);
        check_int("full_issue_cnt", issue_cnt, 128);
        check_int("full_first_valid", first_valid, t0 + 4);
        check_int("full_first_addr", first_valid_addr, 0);
        check_int("full_last_cyc", last_cyc, t0 + 131);
        check_int("full_done_cyc", done_cyc, t0 + 132);

        // Address wrap.
        run(2'd1, 126, 4, 1'b0);
        wait_done("wrap");
        check_int("wrap_last_addr", last_addr, 1);

        // Backpressure: ready held low through t0+20.
        hold_until = 1 << 30;
        run(2'd2, 0, 128, 1'b0);
        hold_until = t0 + 20;
        wait_done("bp");
        check_int("bp_issues_before_pop", issues_at_first_pop, DEPTH);
        hold_until = -1;

        // Empty readout.
        run(2'd0, 17, 0, 1'b0);
        wait_done("empty");
        check_int("empty_issue_cnt", issue_cnt, 0);
        check_int("empty_done_cyc", done_cyc, t0 + 2);
        check_int("empty_busy_first", busy_first, t0 + 1);
        check_int("empty_busy_last", busy_last, t0 + 2);
        check_int("empty_busy_cnt", busy_cnt, 2);

        // Reserved select is ignored.
        run(2'd3, 5, 5, 1'b0);
        repeat (8) @(posedge clk);
        check_int("sel3_busy_cnt", busy_cnt, 0);
        check_int("sel3_issue_cnt", issue_cnt, 0);

        // Random readouts with 30% ready and a stray start while busy.
        ready_pct = 30;
        for (int r = 0; r < 16; r++) begin
            int b, n;
            b = $urandom_range(0, 127);
            n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 128);
            run(2'($urandom_range(0, 2)), b, n, n > 0);
            wait_done("rand");
        end

        // Reset with words buffered and in flight, then a clean readout.
        ready_pct = 0;
        run(2'd1, 10, 50, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        clear_queues();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        ready_pct = 100;
        run(2'd2, 100, 10, 1'b0);
        wait_done("after_rst");
        check_int("after_rst_first_addr", first_valid_addr, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
